// File: rtl/b_wordline_fifo.sv
// Write-side word buffer feeding the B wordline memory stage.
// In-order valid/ready FIFO with show-ahead head word. The depth need not be a
// power of two, so the pointers wrap explicitly at DEPTH-1.

package mixedInclude_package;
    localparam int BSIZE      = 10;
    localparam int BSIZE_LOG2 = 4;
endpackage

module b_wordline_fifo
    import mixedInclude_package::*;
#(
    parameter int DEPTH  = BSIZE,
    parameter int PTR_W  = BSIZE_LOG2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              overflow_err
);

    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_overflow;

    logic w_push;
    logic w_pop;

    // Explicit wrap: pointer values DEPTH..2**PTR_W-1 are never produced.
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Status and handshake outputs depend only on registered state.
    assign full         = (r_cnt == CNT_W'(DEPTH));
    assign empty        = (r_cnt == '0);
    assign push_ready   = !full;
    assign pop_valid    = !empty;
    assign count        = r_cnt;
    assign overflow_err = r_overflow;
    assign pop_data     = r_mem[r_rd_ptr];

    // Flush (and reset) override both handshakes on the same edge.
    assign w_push = push_valid && push_ready && !flush && !rst;
    assign w_pop  = pop_valid  && pop_ready  && !flush && !rst;

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky overflow flag: a push attempt into a full buffer; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (push_valid && full && !flush) begin
            r_overflow <= 1'b1;
        end
    end

    // Upstream must hold a stalled word until it is accepted.
    a_push_hold : assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=> $stable(push_data));

    // The presented head word must not change while it waits to be taken.
    a_pop_hold : assert property (@(posedge clk) disable iff (rst)
        (pop_valid && !pop_ready && !flush) |=> $stable(pop_data));

endmodule

// File: tb/tb_b_wordline_fifo.sv
// Bench for b_wordline_fifo: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a negedge monitor.

module tb_b_wordline_fifo;

    localparam int DEPTH  = 10;
    localparam int PTR_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              overflow_err;

    b_wordline_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_data    (push_data),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the ordered list of stored words and the sticky flag.
    logic [DATA_W-1:0] mq[$];
    logic              m_ovf   = 1'b0;
    bit                armed   = 1'b0;
    int                n_popped = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT state against the model, then apply the coming edge.
    always @(negedge clk) begin
        logic do_pop;
        logic do_push;
        if (armed) begin
            chk("count",      64'(count),        64'(mq.size()));
            chk("empty",      64'(empty),        64'(mq.size() == 0));
            chk("full",       64'(full),         64'(mq.size() == DEPTH));
            chk("push_ready", 64'(push_ready),   64'(mq.size() != DEPTH));
            chk("pop_valid",  64'(pop_valid),    64'(mq.size() != 0));
            chk("overflow",   64'(overflow_err), 64'(m_ovf));
        end
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            if (flush) begin
                mq.delete();
            end else begin
                if (push_valid && mq.size() == DEPTH) m_ovf = 1'b1;
                do_pop  = pop_ready && (mq.size() > 0);
                do_push = push_valid && (mq.size() < DEPTH);
                if (do_pop) begin
                    chk("pop_data", 64'(pop_data), 64'(mq.pop_front()));
                    n_popped++;
                end
                if (do_push) mq.push_back(push_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            push_valid = 1'b1;
            push_data  = base + DATA_W'(i);
            step();
        end
        push_valid = 1'b0;
    endtask

    task automatic drain_expect(input int n, input logic [DATA_W-1:0] base);
        pop_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("drain_data", 64'(pop_data), 64'(base + DATA_W'(i)));
            step();
        end
        pop_ready = 1'b0;
    endtask

    initial begin
        int pc;
        logic stalled;
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pready", 64'(push_ready), 64'd1);
        chk("rst_pvalid", 64'(pop_valid), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        step();

        // Fill, overflow attempt, drain in order
        push_words(10, 32'hA0);
        @(negedge clk);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd10);
        push_valid = 1'b1; push_data = 32'hAA;
        step();
        @(negedge clk);
        chk("ovf_pready", 64'(push_ready), 64'd0);
        chk("ovf_set", 64'(overflow_err), 64'd1);
        step();
        push_valid = 1'b0;
        drain_expect(10, 32'hA0);
        @(negedge clk);
        chk("drain_empty", 64'(empty), 64'd1);
        step();
        push_words(5, 32'hB0);
        drain_expect(5, 32'hB0);

        // Concurrent push/pop at count=5 across two pointer wraps
        push_words(5, 32'hC0);
        pop_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_valid = 1'b1;
            push_data  = 32'hC5 + DATA_W'(i);
            step();
            @(negedge clk);
            chk("steady_count", 64'(count), 64'd5);
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        step();
        drain_expect(5, 32'hC0 + 32'd20);

        // Full with simultaneous pop and push attempt
        push_words(10, 32'hD0);
        push_valid = 1'b1; push_data = 32'hDA; pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_count", 64'(count), 64'd9);
        chk("fullpop_pready", 64'(push_ready), 64'd1);
        step();
        push_valid = 1'b0;
        @(negedge clk);
        chk("fullpop_refill", 64'(count), 64'd10);
        step();
        drain_expect(9, 32'hD1);
        drain_expect(1, 32'hDA);

        // Flush at count=7 with both handshakes requested
        push_words(7, 32'hE0);
        pc = n_popped;
        flush = 1'b1; push_valid = 1'b1; push_data = 32'hEE; pop_ready = 1'b1;
        step();
        chk("flush_nopop", 64'(n_popped), 64'(pc));
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        @(negedge clk);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_ovf_kept", 64'(overflow_err), 64'd1);
        step();

        // Reset mid-stream at count=4
        push_words(4, 32'hF0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_ovf", 64'(overflow_err), 64'd0);
        step();
        push_words(1, 32'h55);
        @(negedge clk);
        chk("midrst_pvalid", 64'(pop_valid), 64'd1);
        chk("midrst_data", 64'(pop_data), 64'h55);
        step();
        drain_expect(1, 32'h55);

        // Randomized traffic with occasional flush and reset
        stalled = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!stalled) begin
                push_valid = ($urandom_range(0, 99) < 60);
                push_data  = $urandom;
            end
            pop_ready = ($urandom_range(0, 99) < 45);
            flush     = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 299) == 0);
            stalled   = push_valid && !push_ready;
            step();
        end
        rst = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
